// File: rtl/cond_pkg.sv
// Shared definitions for the condition/flag unit and anything that models it.
//   cond_t    : 4-bit instruction condition field (EQ..AL, UNC)
//   FLAG_*    : bit positions of N, Z, C, V inside the 4-bit flag vector
//   cond_eval : evaluates a condition code against a {N,Z,C,V} flag vector
package cond_pkg;

  typedef enum logic [3:0] {
    EQ  = 4'd0,
    NE  = 4'd1,
    CS  = 4'd2,
    CC  = 4'd3,
    MI  = 4'd4,
    PL  = 4'd5,
    VS  = 4'd6,
    VC  = 4'd7,
    HI  = 4'd8,
    LS  = 4'd9,
    GE  = 4'd10,
    LT  = 4'd11,
    GT  = 4'd12,
    LE  = 4'd13,
    AL  = 4'd14,
    UNC = 4'd15
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // An unknown condition field matches no case item and falls to the
  // default, so an X/Z condition never lets an instruction through.
  function automatic logic cond_eval(input cond_t c, input logic [3:0] f);
    logic r;
    logic n, z, cf, v;
    n  = f[FLAG_N];
    z  = f[FLAG_Z];
    cf = f[FLAG_C];
    v  = f[FLAG_V];
    r  = 1'b0;
    case (c)
      EQ:      r = z;
      NE:      r = ~z;
      CS:      r = cf;
      CC:      r = ~cf;
      MI:      r = n;
      PL:      r = ~n;
      VS:      r = v;
      VC:      r = ~v;
      HI:      r = cf & ~z;
      LS:      r = ~cf | z;
      GE:      r = (n == v);
      LT:      r = (n != v);
      GT:      r = ~z & (n == v);
      LE:      r = z | (n != v);
      AL:      r = 1'b1;
      UNC:     r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/flag_reg.sv
// Architectural flag register with independently writable NZ and CV halves.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset, clears all flags
//   en_i  : advance enable; 0 holds the register regardless of we_i
//   we_i  : [1] write NZ half, [0] write CV half
//   d_i   : new {N,Z,C,V}
//   q_o   : stored {N,Z,C,V}
module flag_reg
  import cond_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] we_i,
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);

  logic [3:0] flags_q;
  logic [3:0] flags_d;

  always_comb begin
    flags_d = flags_q;
    if (en_i) begin
      if (we_i[1]) flags_d[FLAG_N:FLAG_Z] = d_i[FLAG_N:FLAG_Z];
      if (we_i[0]) flags_d[FLAG_C:FLAG_V] = d_i[FLAG_C:FLAG_V];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) flags_q <= 4'b0000;
    else       flags_q <= flags_d;
  end

  assign q_o = flags_q;

endmodule

// File: rtl/cond_flags_unit.sv
// Condition evaluation, flag register and datapath strobe gating.
//   clk, reset : clock (rising edge), asynchronous active-high reset
//   en         : advance enable; 0 stalls flag and output registers
//   cond       : condition field of the current instruction
//   aluflags   : {N,Z,C,V} from the ALU, same cycle as cond
//   flag_w     : [1] request NZ update, [0] request CV update
//   pcs/regw/memw : decoded PC / register / memory write requests
//   nowrite    : compare-type op, suppresses the register write only
//   flags      : stored {N,Z,C,V}
//   cond_ex, pcsrc, regwrite, memwrite : gated results
// PIPE = 0 gives combinational strobes; PIPE = 1 registers them (1 cycle).
module cond_flags_unit
  import cond_pkg::*;
#(
  parameter int PIPE = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] cond,
  input  logic [3:0] aluflags,
  input  logic [1:0] flag_w,
  input  logic       pcs,
  input  logic       regw,
  input  logic       memw,
  input  logic       nowrite,
  output logic [3:0] flags,
  output logic       cond_ex,
  output logic       pcsrc,
  output logic       regwrite,
  output logic       memwrite
);

  logic       cond_ok;
  logic [1:0] flag_we;
  logic [3:0] strobe_d;

  // Evaluated against the stored flags, so a flag-setting instruction
  // never influences its own condition.
  assign cond_ok = cond_eval(cond_t'(cond), flags);

  // A failed condition blocks both halves of the flag update.
  assign flag_we = flag_w & {2{cond_ok}};

  flag_reg u_flag_reg (
    .clk_i (clk),
    .rst_i (reset),
    .en_i  (en),
    .we_i  (flag_we),
    .d_i   (aluflags),
    .q_o   (flags)
  );

  // Packed as {cond_ex, pcsrc, regwrite, memwrite}.
  assign strobe_d = {cond_ok,
                     pcs & cond_ok,
                     regw & cond_ok & ~nowrite,
                     memw & cond_ok};

  generate
    if (PIPE != 0) begin : g_pipe
      logic [3:0] strobe_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset)   strobe_q <= 4'b0000;
        else if (en) strobe_q <= strobe_d;
      end

      assign {cond_ex, pcsrc, regwrite, memwrite} = strobe_q;
    end else begin : g_comb
      assign {cond_ex, pcsrc, regwrite, memwrite} = strobe_d;
    end
  endgenerate

endmodule

// File: tb/tb_cond_flags_unit.sv
// Bench for cond_flags_unit: one PIPE=0 and one PIPE=1 instance share the
// same stimulus. Directed sequences, a table of condition vectors and a
// randomized run checked against a reference model.
module tb_cond_flags_unit;

  logic       clk;
  logic       reset;
  logic       en;
  logic [3:0] cond;
  logic [3:0] aluflags;
  logic [1:0] flag_w;
  logic       pcs, regw, memw, nowrite;

  logic [3:0] flags0, flags1;
  logic       cond_ex0, pcsrc0, regwrite0, memwrite0;
  logic       cond_ex1, pcsrc1, regwrite1, memwrite1;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  cond_flags_unit #(.PIPE(0)) u_dut0 (
    .clk(clk), .reset(reset), .en(en), .cond(cond), .aluflags(aluflags),
    .flag_w(flag_w), .pcs(pcs), .regw(regw), .memw(memw), .nowrite(nowrite),
    .flags(flags0), .cond_ex(cond_ex0), .pcsrc(pcsrc0),
    .regwrite(regwrite0), .memwrite(memwrite0)
  );

  cond_flags_unit #(.PIPE(1)) u_dut1 (
    .clk(clk), .reset(reset), .en(en), .cond(cond), .aluflags(aluflags),
    .flag_w(flag_w), .pcs(pcs), .regw(regw), .memw(memw), .nowrite(nowrite),
    .flags(flags1), .cond_ex(cond_ex1), .pcsrc(pcsrc1),
    .regwrite(regwrite1), .memwrite(memwrite1)
  );

  // ---------------- reference model ----------------
  // ARM-style decode: cond[3:1] picks a base test, cond[0] inverts it
  // (except for the always-true pair 14/15).
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    if (c[0] && c[3:1] != 3'd7) base = ~base;
    return base;
  endfunction

  // Expected {cond_ex, pcsrc, regwrite, memwrite} for the present inputs.
  function automatic logic [3:0] ref_strobes(input logic [3:0] f);
    logic p;
    p = ref_cond(cond, f);
    return {p, pcs && p, regw && p && !nowrite, memw && p};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input logic [3:0] af, input logic [1:0] fw,
                       input logic p, input logic r, input logic m, input logic nw,
                       input logic e);
    cond = c; aluflags = af; flag_w = fw;
    pcs = p; regw = r; memw = m; nowrite = nw; en = e;
  endtask

  function automatic logic [3:0] s0();
    return {cond_ex0, pcsrc0, regwrite0, memwrite0};
  endfunction

  function automatic logic [3:0] s1();
    return {cond_ex1, pcsrc1, regwrite1, memwrite1};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] preset;
    logic [3:0] c;
    logic p, r, m, nw;
    logic [3:0] exp;  // {cond_ex, pcsrc, regwrite, memwrite}
  } vec_t;

  vec_t vecs[13];

  logic [3:0] m_flags;
  logic [3:0] m_pipe;
  logic [3:0] exp_comb;

  initial begin
    vecs[0]  = '{4'b0000, 4'd8,  1'b1, 1'b1, 1'b1, 1'b0, 4'b0000};
    vecs[1]  = '{4'b0010, 4'd8,  1'b1, 1'b1, 1'b1, 1'b0, 4'b1111};
    vecs[2]  = '{4'b0110, 4'd9,  1'b0, 1'b1, 1'b0, 1'b1, 4'b1000};
    vecs[3]  = '{4'b0000, 4'd12, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1010};
    vecs[4]  = '{4'b1001, 4'd12, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1001};
    vecs[5]  = '{4'b0100, 4'd13, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1100};
    vecs[6]  = '{4'b1000, 4'd13, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1010};
    vecs[7]  = '{4'b0001, 4'd10, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000};
    vecs[8]  = '{4'b1000, 4'd5,  1'b1, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[9]  = '{4'b0001, 4'd6,  1'b0, 1'b0, 1'b1, 1'b0, 4'b1001};
    vecs[10] = '{4'b1111, 4'd3,  1'b0, 1'b1, 1'b0, 1'b0, 4'b0000};
    vecs[11] = '{4'b1111, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1010};
    vecs[12] = '{4'b0000, 4'd7,  1'b0, 1'b1, 1'b0, 1'b0, 4'b1010};

    // ---- reset ----
    reset = 1'b1;
    drive(4'd0, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #3;
    check("reset_flags0", flags0, 4'b0000);
    check("reset_flags1", flags1, 4'b0000);
    check("reset_strobes1", s1(), 4'b0000);
    check("reset_strobes0", s0(), 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    cyc();

    // ---- 1: EQ fails on cleared flags, NE passes ----
    drive(4'd0, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    check("t1_flags", flags0, 4'b0000);
    check("t1_eq_strobes", s0(), 4'b0000);
    cond = 4'd1;
    #1;
    check("t1_ne_strobes", s0(), 4'b1010);
    cyc();
    check("t1_pipe_ne", s1(), 4'b1010);

    // ---- 2: zero result sets Z ----
    drive(4'd14, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc();
    check("t2_flags0", flags0, 4'b0100);
    check("t2_flags1", flags1, 4'b0100);
    drive(4'd0, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    check("t2_eq_pcsrc", {3'b000, pcsrc0}, 4'b0001);
    cond = 4'd1;
    #1;
    check("t2_ne_pcsrc", {3'b000, pcsrc0}, 4'b0000);

    // ---- 3: NZ-only update, signed compare ----
    drive(4'd14, 4'b1001, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    check("t3_own_cond_pre", flags0, 4'b0100);
    cyc();
    check("t3_flags", flags0, 4'b1000);
    drive(4'd10, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    check("t3_ge", {3'b000, cond_ex0}, 4'b0000);
    cond = 4'd11;
    #1;
    check("t3_lt", {3'b000, cond_ex0}, 4'b0001);

    // ---- 4: failed condition blocks flag update and memwrite ----
    drive(4'd14, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc();
    check("t4_clear", flags0, 4'b0000);
    drive(4'd0, 4'b0110, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    #1;
    check("t4_memwrite0", s0(), 4'b0000);
    cyc();
    check("t4_flags_kept", flags0, 4'b0000);
    check("t4_pipe", s1(), 4'b0000);

    // ---- 5: stall holds flags and pipeline register ----
    drive(4'd14, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t5_stall_flags0", flags0, 4'b0000);
      check("t5_stall_flags1", flags1, 4'b0000);
      check("t5_stall_pipe", s1(), 4'b0000);
    end
    en = 1'b1;
    cyc();
    check("t5_release_flags", flags0, 4'b1111);
    check("t5_release_pipe", s1(), 4'b1000);
    drive(4'd14, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    #1;
    check("t5_nowrite", s0(), 4'b1000);

    // ---- 6: PIPE=1 latency and asynchronous reset ----
    drive(4'd14, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc();
    check("t6_regwrite_n1", {3'b000, regwrite1}, 4'b0001);
    regw = 1'b0;
    cyc();
    check("t6_regwrite_n2", {3'b000, regwrite1}, 4'b0000);
    drive(4'd14, 4'b1010, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc();
    check("t6_all_set", s1(), 4'b1111);
    check("t6_flags_set", flags1, 4'b1010);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_strobes", s1(), 4'b0000);
    check("t6_async_flags1", flags1, 4'b0000);
    check("t6_async_flags0", flags0, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    cyc();
    // Inputs still request AL with flag_w=11, so the first edge after
    // reset samples them fresh.
    check("t6_post_reset_flags", flags0, 4'b1010);
    check("t6_post_reset_pipe", s1(), 4'b1111);

    // ---- table of condition vectors ----
    for (int i = 0; i < 13; i++) begin
      drive(4'd14, vecs[i].preset, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc();
      check("tbl_preset", flags0, vecs[i].preset);
      drive(vecs[i].c, 4'b0000, 2'b00, vecs[i].p, vecs[i].r, vecs[i].m, vecs[i].nw, 1'b1);
      #1;
      check($sformatf("tbl%0d_comb", i), s0(), vecs[i].exp);
      cyc();
      check($sformatf("tbl%0d_pipe", i), s1(), vecs[i].exp);
    end

    // ---- randomized run against the model ----
    m_flags = flags0;  // table ended with a known preset; resync below
    m_flags = vecs[12].preset;
    m_pipe  = vecs[12].exp;
    for (int i = 0; i < 300; i++) begin
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0));
      exp_comb = ref_strobes(m_flags);
      #1;
      check("rnd_comb", s0(), exp_comb);
      cyc();
      if (en) begin
        m_pipe = exp_comb;
        if (exp_comb[3] && flag_w[1]) m_flags[3:2] = aluflags[3:2];
        if (exp_comb[3] && flag_w[0]) m_flags[1:0] = aluflags[1:0];
      end
      check("rnd_flags0", flags0, m_flags);
      check("rnd_flags1", flags1, m_flags);
      check("rnd_pipe", s1(), m_pipe);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
